// File: rtl/rtc_time_counter_pkg.sv
// Shared types and constants for the RTC time counter.
// Field widths, wrap limits and the packed time struct.
package rtc_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } rtc_time_t;

endpackage

// File: rtl/rtc_time_counter_if.sv
// Load and time/tick bus of the RTC time counter.
// Alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_time_counter_if;
  import rtc_pkg::*;

  logic              set_valid;
  logic [SEC_W-1:0]  set_sec;
  logic [MIN_W-1:0]  set_min;
  logic [HOUR_W-1:0] set_hour;
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic              sec_tick;
  logic              min_tick;
  logic              day_tick;
  logic              set_err;
`ifdef RTC_ALARM_EN
  logic [MIN_W-1:0]  alarm_min;
  logic [HOUR_W-1:0] alarm_hour;
  logic              alarm;
`endif

  modport master (
    output set_valid, set_sec, set_min, set_hour,
`ifdef RTC_ALARM_EN
    output alarm_min, alarm_hour,
    input  alarm,
`endif
    input  sec, min, hour,
    input  sec_tick, min_tick, day_tick, set_err
  );

  modport slave (
    input  set_valid, set_sec, set_min, set_hour,
`ifdef RTC_ALARM_EN
    input  alarm_min, alarm_hour,
    output alarm,
`endif
    output sec, min, hour,
    output sec_tick, min_tick, day_tick, set_err
  );

endinterface

// File: rtl/rtc_prescaler.sv
// Divides the system clock to a one-cycle strobe every TICK_DIV
// cycles; holds while run_en is low, clear restarts from 0.
module rtc_prescaler #(
  parameter int TICK_DIV = 65536
) (
  input  logic clock,
  input  logic reset,
  input  logic run_en,
  input  logic clear,
  output logic strobe
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign strobe = (cnt == LAST) && run_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run_en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_time_counter.sv
// Binary hh:mm:ss real-time clock with load, run/hold and ticks.
// Optional alarm comparator: define RTC_ALARM_EN.
module rtc_time_counter
  import rtc_pkg::*;
#(
  parameter int TICK_DIV      = 65536,
  parameter int HOURS_PER_DAY = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                run_en,
  rtc_time_counter_if.slave   bus
);

  localparam logic [HOUR_W-1:0] HOUR_LAST =
    HOUR_W'(HOURS_PER_DAY - 1);
  localparam logic [HOUR_W:0] HOUR_LIM =
    (HOUR_W + 1)'(HOURS_PER_DAY);

  rtc_time_t cur;
  rtc_time_t nxt;
  logic      strobe;
  logic      load_ok;
  logic      adv;
  logic      sec_wrap;
  logic      min_wrap;
  logic      hour_wrap;
  logic      sec_tick_q;
  logic      min_tick_q;
  logic      day_tick_q;
  logic      set_err_q;

  assign load_ok = bus.set_valid
                && (bus.set_sec <= SEC_MAX)
                && (bus.set_min <= MIN_MAX)
                && ({1'b0, bus.set_hour} < HOUR_LIM);

  // A rejected load freezes the prescaler for that cycle.
  rtc_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .run_en (run_en & ~bus.set_valid),
    .clear  (load_ok),
    .strobe (strobe)
  );

  assign adv       = strobe & ~bus.set_valid;
  assign sec_wrap  = (cur.sec == SEC_MAX);
  assign min_wrap  = sec_wrap && (cur.min == MIN_MAX);
  assign hour_wrap = min_wrap && (cur.hour == HOUR_LAST);

  always_comb begin
    nxt = cur;
    unique case (1'b1)
      load_ok: begin
        nxt.sec  = bus.set_sec;
        nxt.min  = bus.set_min;
        nxt.hour = bus.set_hour;
      end
      adv: begin
        nxt.sec = sec_wrap ? '0 : cur.sec + 1'b1;
        if (sec_wrap)
          nxt.min = min_wrap ? '0 : cur.min + 1'b1;
        if (min_wrap)
          nxt.hour = hour_wrap ? '0 : cur.hour + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur        <= '0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
      set_err_q  <= 1'b0;
    end else begin
      cur        <= nxt;
      sec_tick_q <= adv;
      min_tick_q <= adv && sec_wrap;
      day_tick_q <= adv && hour_wrap;
      set_err_q  <= bus.set_valid && !load_ok;
    end
  end

  assign bus.sec      = cur.sec;
  assign bus.min      = cur.min;
  assign bus.hour     = cur.hour;
  assign bus.sec_tick = sec_tick_q;
  assign bus.min_tick = min_tick_q;
  assign bus.day_tick = day_tick_q;
  assign bus.set_err  = set_err_q;

`ifdef RTC_ALARM_EN
  logic alarm_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= adv && sec_wrap
              && (nxt.min == bus.alarm_min)
              && (nxt.hour == bus.alarm_hour);
    end
  end

  assign bus.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_rtc_time_counter.sv
// Bench for rtc_time_counter: seconds-of-day model plus
// hand-computed directed checks (TICK_DIV = 4).
module tb_rtc_time_counter;

  localparam int TD  = 4;
  localparam int HPD = 24;
  localparam int DAY = HPD * 3600;

  logic clock;
  logic reset;
  logic run_en;

  int checks   = 0;
  int failures = 0;

  rtc_time_counter_if bus ();

  rtc_time_counter #(
    .TICK_DIV      (TD),
    .HOURS_PER_DAY (HPD)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .run_en (run_en),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: time as seconds of day, prescaler as an integer.
  int m_p;
  int m_t;
  bit m_st, m_mt, m_dt, m_err, m_al;
  int al_min;

  function automatic bit legal();
    return bus.set_sec <= 59 && bus.set_min <= 59
        && bus.set_hour < HPD;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_p <= 0; m_t <= 0;
      m_st <= 0; m_mt <= 0; m_dt <= 0;
      m_err <= 0; m_al <= 0;
    end else begin
      m_st <= 0; m_mt <= 0; m_dt <= 0;
      m_err <= 0; m_al <= 0;
      if (bus.set_valid) begin
        if (legal()) begin
          m_t <= bus.set_hour * 3600 + bus.set_min * 60
               + bus.set_sec;
          m_p <= 0;
        end else begin
          m_err <= 1;
        end
      end else if (run_en) begin
        if (m_p == TD - 1) begin
          m_p  <= 0;
          m_t  <= (m_t + 1) % DAY;
          m_st <= 1;
          m_mt <= ((m_t + 1) % 60) == 0;
          m_dt <= ((m_t + 1) % DAY) == 0;
          m_al <= ((m_t + 1) % 60) == 0
               && ((m_t + 1) % DAY) / 60 == al_min;
        end else begin
          m_p <= m_p + 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("sec", int'(bus.sec), m_t % 60);
    chk("min", int'(bus.min), (m_t / 60) % 60);
    chk("hour", int'(bus.hour), m_t / 3600);
    chk("sec_tick", int'(bus.sec_tick), int'(m_st));
    chk("min_tick", int'(bus.min_tick), int'(m_mt));
    chk("day_tick", int'(bus.day_tick), int'(m_dt));
    chk("set_err", int'(bus.set_err), int'(m_err));
`ifdef RTC_ALARM_EN
    chk("alarm", int'(bus.alarm), int'(m_al));
`endif
  end

  task automatic step(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(int h, int m, int s);
    bus.set_valid = 1'b1;
    bus.set_hour  = 5'(h);
    bus.set_min   = 6'(m);
    bus.set_sec   = 6'(s);
    step(1);
    bus.set_valid = 1'b0;
  endtask

  task automatic chk_time(string name, int h, int m, int s);
    chk({name, "_h"}, int'(bus.hour), h);
    chk({name, "_m"}, int'(bus.min), m);
    chk({name, "_s"}, int'(bus.sec), s);
  endtask

  initial begin
    reset = 1'b0;
    run_en = 1'b0;
    bus.set_valid = 1'b0;
    bus.set_sec = '0;
    bus.set_min = '0;
    bus.set_hour = '0;
    al_min = 1;
`ifdef RTC_ALARM_EN
    bus.alarm_min = 6'd1;
    bus.alarm_hour = 5'd0;
`endif
    #1;
    chk_time("rst", 0, 0, 0);
    chk("rst_ticks", int'({bus.sec_tick, bus.min_tick,
        bus.day_tick, bus.set_err}), 0);

    @(posedge clock);
    #1;
    reset = 1'b1;
    run_en = 1'b1;

    step(3);
    chk("cnt3_sec", int'(bus.sec), 0);
    step(1);
    chk("cnt4_sec", int'(bus.sec), 1);
    chk("cnt4_tick", int'(bus.sec_tick), 1);

    step(236);
    chk_time("c240", 0, 1, 0);
    chk("c240_mtick", int'(bus.min_tick), 1);
    chk("c240_stick", int'(bus.sec_tick), 1);
`ifdef RTC_ALARM_EN
    chk("c240_alarm", int'(bus.alarm), 1);
`endif
    step(1);
    chk("c241_mtick", int'(bus.min_tick), 0);

    run_en = 1'b0;
    step(10);
    chk_time("hold", 0, 1, 0);
    run_en = 1'b1;
    step(2);
    chk("resume2_sec", int'(bus.sec), 0);
    step(1);
    chk("resume3_sec", int'(bus.sec), 1);
    chk("resume3_tick", int'(bus.sec_tick), 1);

    load(12, 34, 56);
    chk_time("ld", 12, 34, 56);
    chk("ld_tick", int'(bus.sec_tick), 0);
    step(3);
    chk("ld3_sec", int'(bus.sec), 56);
    step(1);
    chk_time("ld4", 12, 34, 57);
    chk("ld4_tick", int'(bus.sec_tick), 1);

    load(1, 2, 60);
    chk("rej_err", int'(bus.set_err), 1);
    chk_time("rej", 12, 34, 57);
    step(1);
    chk("rej_err_end", int'(bus.set_err), 0);
    load(24, 0, 0);
    chk("rejh_err", int'(bus.set_err), 1);
    chk_time("rejh", 12, 34, 57);

    load(23, 59, 59);
    step(4);
    chk_time("day", 0, 0, 0);
    chk("day_ticks", int'({bus.sec_tick, bus.min_tick,
        bus.day_tick}), 7);
    step(1);
    chk("day_end", int'({bus.sec_tick, bus.min_tick,
        bus.day_tick}), 0);

    load(5, 0, 0);
    step(3);
    load(1, 2, 3);
    chk_time("coll", 1, 2, 3);
    chk("coll_tick", int'(bus.sec_tick), 0);
    step(4);
    chk_time("coll4", 1, 2, 4);

    load(0, 1, 0);
    chk_time("al_ld", 0, 1, 0);
`ifdef RTC_ALARM_EN
    chk("al_ld_alarm", int'(bus.alarm), 0);
`endif
    chk("al_ld_mtick", int'(bus.min_tick), 0);

    step(2);
    #2;
    reset = 1'b0;
    #1;
    chk_time("mid_rst", 0, 0, 0);
    chk("mid_rst_ticks", int'({bus.sec_tick, bus.min_tick,
        bus.day_tick, bus.set_err}), 0);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_time_counter.md
# rtc_time_counter

Parametrised real-time clock core that divides the system clock down to a 1 Hz strobe and keeps seconds, minutes and hours in binary. It adds run/hold control, a synchronous time-load port with range checking, and cascaded tick pulses. It sits between the top-level pin wrapper and the display/driver logic. An optional alarm comparator can be compiled in.

## Interface
- TICK_DIV, 65536 — clock cycles per second; legal range ≥ 2; prescaler width is $clog2(TICK_DIV).
- HOURS_PER_DAY, 24 — hour wrap value; legal range 2..32; hour field is 5 bits.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- run_en  in  1  1 = timekeeping advances; 0 = prescaler and time frozen.
- set_valid  in  1  one-cycle load request for set_sec/set_min/set_hour.
- set_sec  in  6  seconds to load.
- set_min  in  6  minutes to load.
- set_hour  in  5  hours to load.
- sec  out  6  current seconds, 0..59.
- min  out  6  current minutes, 0..59.
- hour  out  5  current hours, 0..HOURS_PER_DAY-1.
- sec_tick  out  1  one-cycle pulse, concurrent with each seconds update.
- min_tick  out  1  one-cycle pulse when sec wraps 59→0.
- day_tick  out  1  one-cycle pulse when hour wraps to 0.
- set_err  out  1  one-cycle pulse when a load is rejected.
- alarm_min  in  6  alarm minute; present only with RTC_ALARM_EN.
- alarm_hour  in  5  alarm hour; present only with RTC_ALARM_EN.
- alarm  out  1  one-cycle pulse on alarm match; present only with RTC_ALARM_EN.

## Operation
- Reset state: prescaler = 0, sec = min = hour = 0, and all pulse outputs = 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 while run_en = 1, then wraps to 0.
  - The internal strobe is (prescaler == TICK_DIV-1) && run_en.
- On the strobe, sec increments.
  - At 59, sec wraps to 0 and min increments.
  - At 59, min wraps to 0 and hour increments.
  - At HOURS_PER_DAY-1, hour wraps to 0.
- Tick pulses are registered. Each is high for exactly the one cycle in which the new value is first visible on the outputs.
- Load:
  - A load is accepted when set_sec ≤ 59, set_min ≤ 59 and set_hour < HOURS_PER_DAY.
  - Accepted load: all three fields load, the prescaler clears to 0, and no tick pulse is generated.
  - Rejected load: time is unchanged, the prescaler is unchanged, and set_err pulses on the next cycle.
- Load takes priority over a strobe in the same cycle; that strobe is discarded.
- Load is honoured regardless of run_en.
- run_en low holds every register. Ticks resume from the held prescaler value once run_en returns high.
- Asserting reset at any time returns all state to the reset values immediately. No pulse is generated on reset release.

## Timing
- After reset release with run_en held high, the first sec_tick occurs with sec = 1, exactly TICK_DIV cycles after the first active edge.
- After an accepted load, the next sec increment occurs TICK_DIV cycles later.
- Output latency:
  - Output registers update on the edge where the strobe is sampled.
  - Pulses are aligned with the updated values.
  - There is no combinational path from any input to any output.
- Ripple at day wrap: the 23:59:59 → 00:00:00 transition asserts sec_tick, min_tick and day_tick in the same cycle.

## Configuration
- RTC_ALARM_EN defined:
  - Adds alarm_min, alarm_hour and alarm.
  - alarm pulses together with the min_tick whose new value has min == alarm_min and hour == alarm_hour (time hh:mm:00).
  - An accepted load never triggers alarm.
- RTC_ALARM_EN undefined: the alarm ports and logic are absent. All other behaviour is identical.

## Structure
- Package rtc_pkg holds:
  - SEC_MAX = 59, MIN_MAX = 59.
  - Field widths: SEC_W = 6, MIN_W = 6, HOUR_W = 5.
  - A packed time struct (hour, min, sec).
- One sub-module, rtc_prescaler: parameter TICK_DIV; inputs clock, reset, run_en, clear; output strobe.
- The time registers, wrap logic, load check and alarm remain in rtc_time_counter.

## Test plan
- Count and wrap: TICK_DIV = 4, run_en = 1 after reset → sec = 1 at cycle 4; sec = 59→0 with min_tick after 240 cycles; min = 1.
- Day wrap: load 23:59:59 → after 4 cycles, time reads 00:00:00 with sec_tick, min_tick and day_tick all high for one cycle.
- Hold: drop run_en for 10 cycles mid-count → sec and prescaler are unchanged; the tick resumes at the remaining cycle count.
- Load checks:
  - set_valid with 12:34:56 → outputs read 12:34:56 next cycle; next tick 4 cycles later reads 12:34:57.
  - set_sec = 60 → set_err pulse; time unchanged.
- Collision and reset:
  - set_valid in the same cycle as the strobe → the loaded value wins; no sec_tick.
  - Reset asserted mid-count → all outputs are 0 immediately.
- RTC_ALARM_EN: alarm = 00:01, run from reset → alarm pulses once at cycle 240 with min_tick. A load of 00:01:00 → no alarm.
